// File: rtl/hann_window_ctrl_pkg.sv
// hann_window_ctrl_pkg: shared state encoding, rounding constant and default sizes
package hann_window_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam int ROUND_Q16 = 32'h8000;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FRAME_LEN = 1024;
endpackage

// File: rtl/hann_mul_round.sv
// hann_mul_round: signed sample times unsigned Q0.16 coefficient, rounded back to sample width
module hann_mul_round
  import hann_window_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic signed [DATA_WIDTH-1:0] sample,
  input  logic        [DATA_WIDTH-1:0] coef,
  output logic signed [DATA_WIDTH-1:0] product
);
  localparam int PW = 2 * DATA_WIDTH + 1;
  logic signed [PW-1:0] full;
  // Coefficient is zero-extended so it always multiplies as a non-negative fraction
  assign full = PW'(sample) * $signed(PW'(coef)) + PW'(ROUND_Q16);
  // Coefficient is below 1.0, so the shifted result always fits the sample width
  assign product = DATA_WIDTH'(full >>> DATA_WIDTH);
endmodule

// File: rtl/hann_window_ctrl.sv
// hann_window_ctrl: sequences the Hann coefficient RAM and windows a PCM sample stream
module hann_window_ctrl
  import hann_window_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAME_LEN  = DEF_FRAME_LEN
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         frame_done,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [DATA_WIDTH-1:0] s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic        [DATA_WIDTH-1:0] m_data,
  output logic                         m_last,
  input  logic                         cfg_wr_en,
  output logic                         cfg_ready,
  input  logic        [ADDR_WIDTH-1:0] cfg_addr,
  input  logic        [DATA_WIDTH-1:0] cfg_data,
  output logic        [ADDR_WIDTH-1:0] lut_addr,
  output logic        [DATA_WIDTH-1:0] lut_wr_data,
  output logic                         lut_wr_en,
  input  logic        [DATA_WIDTH-1:0] lut_rd_data
);
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] idx, addr_hold;
  logic p1_valid, p1_last;
  logic signed [DATA_WIDTH-1:0] p1_sample, product;
  logic adv, accept, idx_last, cfg_hs;

  assign adv = !m_valid | m_ready;
  assign s_ready = (state == RUN) & adv;
  assign accept = s_valid & s_ready;
  assign idx_last = idx == ADDR_WIDTH'(FRAME_LEN - 1);
  assign cfg_ready = (state == IDLE) & !start;
  assign cfg_hs = cfg_wr_en & cfg_ready;
  assign lut_wr_en = cfg_hs;
  assign lut_wr_data = cfg_data;
  // Holding the address during stalls makes the RAM re-read the same coefficient
  assign lut_addr = cfg_hs ? cfg_addr : accept ? idx : addr_hold;
  assign busy = state != IDLE;
  assign frame_done = m_valid & m_ready & m_last;

  // Next state: run until the last sample is taken, drain until it leaves the output
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE && start) ? RUN :
                (state == RUN && accept && idx_last) ? DRAIN :
                (state == DRAIN && frame_done) ? IDLE : state;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;

  // Frame index and the held RAM address follow accepted samples
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      addr_hold <= '0;
    end else if (state == IDLE && start) begin
      idx <= '0;
    end else if (accept) begin
      idx <= idx_last ? '0 : idx + ADDR_WIDTH'(1);
      addr_hold <= idx;
    end

  // Stage 1 holds the sample while its coefficient is read from the RAM
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p1_valid <= 1'b0;
      p1_sample <= '0;
      p1_last <= 1'b0;
    end else if (accept) begin
      p1_valid <= 1'b1;
      p1_sample <= s_data;
      p1_last <= idx_last;
    end else if (adv) begin
      p1_valid <= 1'b0;
      p1_last <= 1'b0;
    end

  hann_mul_round #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .sample (p1_sample),
    .coef   (lut_rd_data),
    .product(product)
  );

  // Output register advances when downstream can take a word and holds otherwise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data <= '0;
      m_last <= 1'b0;
    end else if (adv) begin
      m_valid <= p1_valid;
      m_data <= product;
      m_last <= p1_last;
    end
endmodule

// File: tb/tb_hann_window_ctrl.sv
// tb_hann_window_ctrl: scoreboard bench for the Hann windowing controller with a behavioural LUT
module tb_hann_window_ctrl;
  localparam int AW = 10, DW = 16, FL = 1024;
  typedef struct packed { logic [DW-1:0] d; logic l; } exp_t;
  typedef struct { logic [DW-1:0] coef; logic [DW-1:0] samp; logic [DW-1:0] want; } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, s_valid = 1'b0, m_ready = 1'b1, cfg_wr_en = 1'b0;
  logic [DW-1:0] s_data = '0, cfg_data = '0, lut_rd_data, m_data, lut_wr_data;
  logic [AW-1:0] cfg_addr = '0, lut_addr;
  logic busy, frame_done, s_ready, m_valid, m_last, cfg_ready, lut_wr_en;
  logic [DW-1:0] mem [FL];
  logic [DW-1:0] coef_m [FL];
  logic [DW-1:0] samp [FL];
  logic [DW-1:0] expd [FL];
  vec_t tbl [6];
  exp_t sb [$];
  exp_t cur_exp;
  int checks = 0, errors = 0, out_cnt = 0;
  bit bp_en = 1'b0;
  logic prev_stall = 1'b0, prev_l = 1'b0;
  logic [DW-1:0] prev_d = '0;

  always #5 clk = ~clk;

  hann_window_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .frame_done(frame_done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .cfg_wr_en(cfg_wr_en), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .lut_addr(lut_addr), .lut_wr_data(lut_wr_data), .lut_wr_en(lut_wr_en), .lut_rd_data(lut_rd_data)
  );

  // Single-port coefficient RAM with a registered read and no output register
  always @(posedge clk) begin
    if (lut_wr_en) mem[lut_addr] <= lut_wr_data;
    lut_rd_data <= mem[lut_addr];
  end

  // Downstream ready: random when backpressure is enabled
  always @(posedge clk) begin
    #1;
    m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic [DW-1:0] s, input logic [DW-1:0] c);
    longint p;
    p = longint'($signed(s)) * longint'(c) + 64'sd32768;
    return DW'(p >>> 16);
  endfunction

  // Scoreboard: push on accept, pop and compare on output handshake, check holds during stalls
  always @(negedge clk) begin
    exp_t e;
    if (prev_stall) begin
      chk("stall_valid", 32'(m_valid), 32'd1);
      chk("stall_data", 32'(m_data), 32'(prev_d));
      chk("stall_last", 32'(m_last), 32'(prev_l));
    end
    if (s_valid && s_ready) sb.push_back(cur_exp);
    if (m_valid && m_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_data", 32'(m_data), 32'(e.d));
        chk("out_last", 32'(m_last), 32'(e.l));
        chk("frame_done", 32'(frame_done), 32'(e.l));
      end
      out_cnt++;
    end else chk("idle_done", 32'(frame_done), 32'd0);
    chk("wr_outside_idle", 32'(busy && lut_wr_en), 32'd0);
    prev_stall = m_valid && !m_ready;
    prev_d = m_data;
    prev_l = m_last;
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_m_last"}, 32'(m_last), 32'd0);
    chk({tag, "_m_data"}, 32'(m_data), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_lut_wr_en"}, 32'(lut_wr_en), 32'd0);
    chk({tag, "_lut_addr"}, 32'(lut_addr), 32'd0);
  endtask

  task automatic cfg_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cfg_wr_en = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    coef_m[a] = d;
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input exp_t e, input bit gap);
    int n;
    logic ok;
    if (gap) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    s_data = d;
    cur_exp = e;
    n = 0;
    do begin
      @(negedge clk);
      ok = s_ready;
      n++;
      @(posedge clk); #1;
    end while (!ok && n < 200);
    chk("accept_in_time", 32'(ok), 32'd1);
    s_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input bit gap);
    exp_t e;
    for (int i = lo; i <= hi; i++) begin
      e.d = expd[i];
      e.l = (i == FL - 1);
      send(samp[i], e, gap);
    end
  endtask

  task automatic start_frame();
    out_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!(m_valid && m_ready && m_last) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_last_seen"}, 32'(m_valid && m_ready && m_last), 32'd1);
    chk({tag, "_done_pulse"}, 32'(frame_done), 32'd1);
    chk({tag, "_busy_drain"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({tag, "_busy_clear"}, 32'(busy), 32'd0);
    chk({tag, "_valid_clear"}, 32'(m_valid), 32'd0);
    chk({tag, "_out_count"}, 32'(out_cnt), 32'(FL));
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'hFFFF, 16'h4000, 16'h4000};
    tbl[1] = '{16'hFFFF, 16'h8000, 16'h8001};
    tbl[2] = '{16'h0000, 16'h7FFF, 16'h0000};
    tbl[3] = '{16'h8000, 16'hFFFD, 16'hFFFF};
    tbl[4] = '{16'h8000, 16'h0003, 16'h0002};
    tbl[5] = '{16'h1234, 16'h7FFF, 16'h091A};
    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    reset_checks("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("idle_s_ready", 32'(s_ready), 32'd0);
    chk("idle_m_valid", 32'(m_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    // Ramp coefficients, constant sample, full throughput
    for (int i = 0; i < FL; i++) cfg_write(AW'(i), DW'(i * 64));
    for (int i = 0; i < FL; i++) begin
      samp[i] = 16'h4000;
      expd[i] = DW'((32'h4000 * i * 64 + 32'h8000) >> 16);
    end
    start_frame();
    send_range(0, FL - 1, 1'b0);
    finish_frame("ramp");
    // Rounding corners in the first entries, including a host write at address 5
    for (int k = 0; k < 5; k++) cfg_write(AW'(k), tbl[k].coef);
    cfg_wr_en = 1'b1;
    cfg_addr = 10'd5;
    cfg_data = tbl[5].coef;
    coef_m[5] = tbl[5].coef;
    #1;
    chk("wr5_en", 32'(lut_wr_en), 32'd1);
    chk("wr5_addr", 32'(lut_addr), 32'd5);
    chk("wr5_data", 32'(lut_wr_data), 32'h1234);
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
    for (int i = 0; i < FL; i++) begin
      samp[i] = (i < 6) ? tbl[i].samp : DW'($urandom);
      expd[i] = (i < 6) ? tbl[i].want : model(samp[i], coef_m[i]);
    end
    // Backpressure and gapped input, with a refused host write held through the frame
    bp_en = 1'b1;
    start_frame();
    cfg_wr_en = 1'b1;
    cfg_addr = 10'd7;
    cfg_data = 16'hFFFF;
    @(negedge clk);
    chk("run_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("run_wr_en", 32'(lut_wr_en), 32'd0);
    chk("run_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    send_range(0, FL - 1, 1'b1);
    cfg_wr_en = 1'b0;
    finish_frame("bp");
    bp_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Start beats a simultaneous write; then reset mid-frame at index 300
    for (int i = 0; i < FL; i++) begin
      samp[i] = DW'($urandom);
      expd[i] = model(samp[i], coef_m[i]);
    end
    out_cnt = 0;
    start = 1'b1;
    cfg_wr_en = 1'b1;
    cfg_addr = 10'd9;
    cfg_data = 16'h0000;
    @(negedge clk);
    chk("start_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("start_wr_en", 32'(lut_wr_en), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    cfg_wr_en = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    send_range(0, 300, 1'b0);
    chk("pre_reset_valid", 32'(m_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    // A fresh frame after reset must begin at index 0
    for (int i = 0; i < FL; i++) begin
      samp[i] = DW'($urandom);
      expd[i] = model(samp[i], coef_m[i]);
    end
    start_frame();
    send_range(0, FL - 1, 1'b0);
    finish_frame("post_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
